// File: rtl/fully_pkg.sv
// Shared defaults and FSM state type for the fully-connected accumulator layer.
package fully_pkg;

  localparam int FC_DATA_W   = 8;
  localparam int FC_WEIGHT_W = 8;
  localparam int FC_ACC_W    = 24;
  localparam int FC_NUM_IN   = 28;
  localparam int FC_NUM_OUT  = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fully_mac.sv
// Two-stage multiply-accumulate: registered full-precision product, then per-neuron
// accumulation with a result pulse on the neuron's last beat.
module fully_mac
  import fully_pkg::*;
#(
  parameter int DATA_W   = FC_DATA_W,
  parameter int WEIGHT_W = FC_WEIGHT_W,
  parameter int ACC_W    = FC_ACC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              beat,
  input  logic              first,
  input  logic              last,
  input  logic [3:0]        addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [WEIGHT_W-1:0] in_weight,
  output logic              out_valid,
  output logic [3:0]        out_addr,
  output logic [ACC_W-1:0]  out_data
);

  localparam int PROD_W = DATA_W + WEIGHT_W;

  logic signed [DATA_W-1:0]   data_s;
  logic signed [WEIGHT_W-1:0] weight_s;
  logic signed [PROD_W-1:0]   prod_p1;
  logic                       vld_p1;
  logic                       first_p1;
  logic                       last_p1;
  logic [3:0]                 addr_p1;
  logic signed [ACC_W-1:0]    acc_p2;
  logic signed [ACC_W-1:0]    sum_p2;

  function automatic logic signed [ACC_W-1:0] ext_prod(input logic signed [PROD_W-1:0] p);
    return ACC_W'(p);
  endfunction

  assign data_s   = in_data;
  assign weight_s = in_weight;

  // The first beat of a neuron starts from zero, so back-to-back neurons never mix.
  assign sum_p2 = (first_p1 ? '0 : acc_p2) + ext_prod(prod_p1);

  // ---- stage 1: product register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_p1  <= '0;
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
      addr_p1  <= '0;
    end else begin
      vld_p1   <= beat && !clear;
      first_p1 <= first;
      last_p1  <= last;
      addr_p1  <= addr;
      if (beat) begin
        prod_p1 <= PROD_W'(data_s) * PROD_W'(weight_s);
      end
    end
  end

  // ---- stage 2: accumulate and emit ----
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_p2    <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else if (clear) begin
      acc_p2    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= vld_p1 && last_p1;
      if (vld_p1) begin
        acc_p2 <= last_p1 ? '0 : sum_p2;
        if (last_p1) begin
          out_data <= sum_p2;
          out_addr <= addr_p1;
        end
      end
    end
  end

endmodule

// File: rtl/fully_accum.sv
// Fully-connected layer accumulator: frame FSM, beat/neuron counters, address check
// and running argmax around a two-stage MAC.
module fully_accum
  import fully_pkg::*;
#(
  parameter int DATA_W   = FC_DATA_W,
  parameter int WEIGHT_W = FC_WEIGHT_W,
  parameter int ACC_W    = FC_ACC_W,
  parameter int NUM_IN   = FC_NUM_IN,
  parameter int NUM_OUT  = FC_NUM_OUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fully_en,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [WEIGHT_W-1:0] in_weight,
  input  logic [3:0]          in_addr,
  output logic                out_valid,
  output logic [3:0]          out_addr,
  output logic [ACC_W-1:0]    out_data,
  output logic                done,
  output logic [3:0]          class_out,
  output logic                addr_err
);

  localparam int BEAT_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  state_t                  state_q, state_d;
  logic [BEAT_W-1:0]       beat_cnt;
  logic [3:0]              neuron_cnt;
  logic                    drain_cnt;
  logic                    abort;
  logic                    beat;
  logic                    last_beat;
  logic                    frame_end;
  logic                    take;
  logic signed [ACC_W-1:0] res_s;
  logic signed [ACC_W-1:0] max_val;
  logic [3:0]              max_idx;

  assign abort     = !fully_en && (state_q != ST_IDLE);
  assign beat      = (state_q == ST_RUN) && in_valid && fully_en;
  assign last_beat = (beat_cnt == BEAT_W'(NUM_IN - 1));
  assign frame_end = beat && last_beat && (neuron_cnt == 4'(NUM_OUT - 1));
  assign done      = (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (fully_en) state_d = ST_RUN;
      ST_RUN:   if (frame_end) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_cnt) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      beat_cnt   <= '0;
      neuron_cnt <= '0;
      drain_cnt  <= 1'b0;
    end else begin
      state_q   <= state_d;
      drain_cnt <= (state_q == ST_DRAIN) && !drain_cnt && !abort;
      if (abort || state_q == ST_IDLE) begin
        beat_cnt   <= '0;
        neuron_cnt <= '0;
      end else if (beat) begin
        if (last_beat) begin
          beat_cnt   <= '0;
          neuron_cnt <= (neuron_cnt == 4'(NUM_OUT - 1)) ? 4'd0 : neuron_cnt + 4'd1;
        end else begin
          beat_cnt <= beat_cnt + BEAT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_err <= 1'b0;
    end else if (state_q == ST_IDLE && state_d == ST_RUN) begin
      addr_err <= 1'b0;
    end else if (beat && in_addr != neuron_cnt) begin
      addr_err <= 1'b1;
    end
  end

  fully_mac #(
    .DATA_W   (DATA_W),
    .WEIGHT_W (WEIGHT_W),
    .ACC_W    (ACC_W)
  ) u_mac (
    .clk       (clk),
    .reset     (reset),
    .clear     (abort),
    .beat      (beat),
    .first     (beat_cnt == '0),
    .last      (last_beat),
    .addr      (neuron_cnt),
    .in_data   (in_data),
    .in_weight (in_weight),
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .out_data  (out_data)
  );

  // Neuron 0 seeds the max; later neurons replace it only when strictly greater.
  assign res_s = out_data;
  assign take  = out_valid && (out_addr == 4'd0 || res_s > max_val);

  always_ff @(posedge clk) begin
    if (reset) begin
      max_val   <= '0;
      max_idx   <= '0;
      class_out <= '0;
    end else begin
      if (take) begin
        max_val <= res_s;
        max_idx <= out_addr;
      end
      if (state_q == ST_DRAIN && drain_cnt && !abort) begin
        class_out <= take ? out_addr : max_idx;
      end
    end
  end

endmodule

// File: tb/tb_fully_accum.sv
// Randomized scoreboard bench for fully_accum: a frame-level dot-product model feeds
// expected results to a monitor that checks every out_valid and done pulse.
module tb_fully_accum;

  localparam int NI    = 28;
  localparam int NO    = 10;
  localparam int ACC_W = 24;

  logic             clk = 1'b0;
  logic             reset;
  logic             fully_en;
  logic             in_valid;
  logic [7:0]       in_data;
  logic [7:0]       in_weight;
  logic [3:0]       in_addr;
  logic             out_valid;
  logic [3:0]       out_addr;
  logic [ACC_W-1:0] out_data;
  logic             done;
  logic [3:0]       class_out;
  logic             addr_err;

  fully_accum dut (
    .clk       (clk),
    .reset     (reset),
    .fully_en  (fully_en),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_weight (in_weight),
    .in_addr   (in_addr),
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .done      (done),
    .class_out (class_out),
    .addr_err  (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     addr;
    longint val;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   last_ov_cyc = -100;
  int   last_beat_cyc = 0;
  int   cur_class = 0;
  exp_t exp_q[$];
  int   class_q[$];
  bit   err_q[$];
  int   fd[NO][NI];
  int   fw[NO][NI];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      last_ov_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_addr", longint'(out_addr), mon_e.addr);
        chk("out_data", longint'($signed(out_data)), mon_e.val);
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (class_q.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        chk("class_out", longint'(class_out), class_q.pop_front());
        chk("addr_err_at_done", longint'(addr_err), err_q.pop_front());
        chk("done_after_last_out", cyc, last_ov_cyc + 1);
        chk("done_after_last_beat", cyc, last_beat_cyc + 3);
      end
    end
  end

  task automatic fill(input int pat);
    for (int n = 0; n < NO; n++) begin
      for (int b = 0; b < NI; b++) begin
        case (pat)
          0: begin fd[n][b] = 1; fw[n][b] = 1; end
          1: begin fd[n][b] = (n == 3) ? -128 : 0; fw[n][b] = (n == 3) ? -128 : 0; end
          2: begin fd[n][b] = (n == 3) ? -128 : 0; fw[n][b] = (n == 3) ? 127 : 0; end
          3: begin fd[n][b] = (n == 7) ? 5 : 1; fw[n][b] = (n == 7) ? 2 : 1; end
          default: begin
            fd[n][b] = int'($urandom_range(255)) - 128;
            fw[n][b] = int'($urandom_range(255)) - 128;
          end
        endcase
      end
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, longint'(out_valid), 0);
    chk({tag, "_out_addr"}, longint'(out_addr), 0);
    chk({tag, "_out_data"}, longint'(out_data), 0);
    chk({tag, "_done"}, longint'(done), 0);
    chk({tag, "_class_out"}, longint'(class_out), 0);
    chk({tag, "_addr_err"}, longint'(addr_err), 0);
  endtask

  // abort_kind: 0 none, 1 fully_en dropped, 2 reset, applied at (abort_n, abort_b)
  task automatic run_frame(input int gap_pct, input int bad_n, input int abort_kind,
                           input int abort_n, input int abort_b);
    longint sums[NO];
    int     cls;
    int     n_out;
    int     dc0;
    for (int n = 0; n < NO; n++) begin
      sums[n] = 0;
      for (int b = 0; b < NI; b++) sums[n] += longint'(fd[n][b]) * longint'(fw[n][b]);
    end
    cls = 0;
    for (int n = 1; n < NO; n++) if (sums[n] > sums[cls]) cls = n;
    n_out = (abort_kind != 0) ? abort_n : NO;
    for (int n = 0; n < n_out; n++) exp_q.push_back('{addr: n, val: sums[n]});
    if (abort_kind == 0) begin
      class_q.push_back(cls);
      err_q.push_back(bad_n >= 0);
    end

    // junk presented while still IDLE must be ignored
    fully_en  = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'($urandom);
    in_weight = 8'($urandom);
    in_addr   = 4'hF;
    tick();
    chk("addr_err_clear_on_start", longint'(addr_err), 0);

    for (int n = 0; n < NO; n++) begin
      for (int b = 0; b < NI; b++) begin
        if (abort_kind != 0 && n == abort_n && b == abort_b) begin
          in_valid  = 1'b1;
          in_data   = 8'(fd[n][b]);
          in_weight = 8'(fw[n][b]);
          in_addr   = 4'(n);
          dc0 = done_cnt;
          if (abort_kind == 1) begin
            fully_en = 1'b0;
            tick();
            in_valid = 1'b0;
            chk("class_held_on_abort", longint'(class_out), cur_class);
            repeat (8) tick();
            chk("no_done_after_abort", done_cnt, dc0);
          end else begin
            reset = 1'b1;
            tick();
            check_zero_outputs("mid_run_reset");
            reset    = 1'b0;
            fully_en = 1'b0;
            in_valid = 1'b0;
            cur_class = 0;
            repeat (8) tick();
            chk("no_done_after_reset", done_cnt, dc0);
          end
          return;
        end
        for (int g = 0; g < 3 && int'($urandom_range(99)) < gap_pct; g++) begin
          in_valid  = 1'b0;
          in_data   = 8'($urandom);
          in_weight = 8'($urandom);
          in_addr   = 4'hF;
          tick();
        end
        in_valid  = 1'b1;
        in_data   = 8'(fd[n][b]);
        in_weight = 8'(fw[n][b]);
        in_addr   = (n == bad_n && b == 3) ? ((n == 4) ? 4'd5 : 4'd4) : 4'(n);
        last_beat_cyc = cyc;
        tick();
      end
    end

    // junk during the two DRAIN cycles must be ignored
    repeat (2) begin
      in_valid  = 1'b1;
      in_data   = 8'($urandom);
      in_weight = 8'($urandom);
      in_addr   = 4'hF;
      tick();
    end
    in_valid = 1'b0;
    dc0 = done_cnt;
    for (int i = 0; i < 20 && done_cnt == dc0; i++) tick();
    chk("done_seen", done_cnt, dc0 + 1);
    cur_class = cls;
    fully_en = 1'b0;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    fully_en  = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h7F;
    in_weight = 8'h7F;
    in_addr   = 4'd0;
    repeat (3) tick();
    check_zero_outputs("reset");
    reset    = 1'b0;
    fully_en = 1'b0;
    in_valid = 1'b0;
    tick();

    fill(0); run_frame(0, -1, 0, 0, 0);
    fill(1); run_frame(0, -1, 0, 0, 0);
    fill(2); run_frame(30, -1, 0, 0, 0);
    fill(3); run_frame(40, -1, 0, 0, 0);
    fill(0); run_frame(20, 2, 0, 0, 0);
    fill(4); run_frame(20, -1, 1, 5, 15);
    fill(4); run_frame(0, -1, 0, 0, 0);
    fill(4); run_frame(25, 1, 2, 2, 10);
    fill(4); run_frame(10, -1, 0, 0, 0);
    fill(3); run_frame(0, 6, 0, 0, 0);

    repeat (5) tick();
    chk("scoreboard_drained", exp_q.size() + class_q.size() + err_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
